// File: rtl/pipe_mux_reg.sv
// Registered M:1 input mux feeding a two-entry (head + skid) output stage.
// Keeps in_ready free of any combinational path from in_valid or out_ready.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | head holds the oldest entry, skid free
// FULL  | head and skid both hold entries, in_ready=0
module pipe_mux_reg #(
  parameter int          N         = 32,
  parameter int          M         = 4,
  parameter logic [31:0] FLUSH_VAL = 32'h0000_0013,
  localparam int         SW        = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err,
  output logic [15:0]    xfer_cnt
);

  localparam logic [N-1:0] FLUSH_W = N'(FLUSH_VAL);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [N-1:0] head_q, head_d;
  logic [N-1:0] skid_q, skid_d;
  logic         sel_err_q, sel_err_d;
  logic [15:0]  xfer_q, xfer_d;
  logic         rdy_q;

  logic [N-1:0] cap_word;
  logic         sel_ok;
  logic         accept;
  logic         fire;

  // Out-of-range selects capture FLUSH_VAL and flag sel_err.
  always_comb begin
    cap_word = FLUSH_W;
    sel_ok   = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (sel == SW'(k)) begin
        cap_word = in_data[k*N +: N];
        sel_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      head_q    <= FLUSH_W;
      skid_q    <= FLUSH_W;
      sel_err_q <= 1'b0;
      xfer_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
      xfer_q    <= xfer_d;
      rdy_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q;
    xfer_d    = xfer_q;
    accept    = in_valid & in_ready;
    fire      = out_valid & out_ready;
    if (flush) begin
      state_d = EMPTY;
      head_d  = FLUSH_W;
      skid_d  = FLUSH_W;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = cap_word;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            head_d = cap_word;
          end else if (accept) begin
            skid_d  = cap_word;
            state_d = FULL;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (fire)
        xfer_d = xfer_q + 16'd1;
      if (accept && !sel_ok)
        sel_err_d = 1'b1;
    end
  end

  always_comb begin
    in_ready  = rdy_q & (state_q != FULL) & ~flush;
    out_valid = (state_q != EMPTY);
    out_data  = head_q;
    sel_err   = sel_err_q;
    xfer_cnt  = xfer_q;
  end

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Bench for pipe_mux_reg (M=3): FIFO-queue reference model, per-cycle compare
// process, directed scenarios with literal expectations, random traffic and a long stream.
module tb_pipe_mux_reg;
  localparam int N = 32;
  localparam int M = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [M*N-1:0] in_data = '0;
  logic [1:0]     sel = '0;
  logic           in_valid = 1'b0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           sel_err;
  logic [15:0]    xfer_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic [15:0] m_xfer = '0;
  bit          m_err = 1'b0;
  bit          m_rdy = 1'b0;
  bit          streaming = 1'b0;
  int          ir_low = 0;

  pipe_mux_reg #(.N(N), .M(M), .FLUSH_VAL(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [M*N-1:0] d, input logic [1:0] s);
    if (int'(s) >= M) return 32'h0000_0013;
    return 32'(d >> (int'(s) * 32));
  endfunction

  // Entry queue: pop on transfer, then push on accept; flush empties it.
  task automatic model_step();
    bit ir;
    bit ov;
    ir = m_rdy && (mq.size() < 2) && !flush;
    ov = (mq.size() > 0);
    if (flush) begin
      mq.delete();
    end else begin
      if (ov && out_ready) begin
        void'(mq.pop_front());
        m_xfer++;
      end
      if (in_valid && ir) begin
        mq.push_back(pick(in_data, sel));
        if (int'(sel) >= M) m_err = 1'b1;
      end
    end
    m_rdy = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must respond before the next edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    mq.delete();
    m_xfer = '0;
    m_err = 1'b0;
    m_rdy = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'h0000_0013);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_xfer_cnt", xfer_cnt, 32'd0);
    check("rst_sel_err", sel_err, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    check("cyc_in_ready", in_ready, rst && m_rdy && (mq.size() < 2) && !flush);
    check("cyc_out_valid", out_valid, mq.size() > 0);
    check("cyc_sel_err", sel_err, m_err);
    check("cyc_xfer_cnt", xfer_cnt, m_xfer);
    if (mq.size() > 0) check("cyc_out_data", out_data, mq[0]);
    if (streaming && !in_ready) ir_low++;
  end

  initial begin
    #1;
    do_reset();
    cycle();

    // single word through the mux, then its transfer
    in_data = {32'hA5A5_0002, 32'h0, 32'h0};
    sel = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("d1_out_data", out_data, 32'hA5A5_0002);
    check("d1_out_valid", out_valid, 32'd1);
    in_valid = 1'b0;
    cycle();
    check("d1_xfer_cnt", xfer_cnt, 32'd1);
    check("d1_drained", out_valid, 32'd0);

    // fill to FULL under backpressure, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd0;
    in_data = {64'h0, 32'h11};
    cycle();
    in_data = {64'h0, 32'h22};
    cycle();
    in_valid = 1'b0;
    #1;
    check("d2_full_in_ready", in_ready, 32'd0);
    check("d2_hold_data", out_data, 32'h11);
    cycle();
    check("d2_hold_data2", out_data, 32'h11);
    out_ready = 1'b1;
    cycle();
    check("d2_second_word", out_data, 32'h22);
    cycle();
    check("d2_empty", out_valid, 32'd0);
    check("d2_xfer_cnt", xfer_cnt, 32'd3);

    // out-of-range select, sticky through flush
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd3;
    cycle();
    check("d3_bad_sel_data", out_data, 32'h0000_0013);
    check("d3_sel_err", sel_err, 32'd1);
    in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("d3_sel_err_after_flush", sel_err, 32'd1);
    check("d3_flushed", out_valid, 32'd0);

    // flush from FULL overrides coincident accept and fire
    sel = 2'd0;
    in_valid = 1'b1;
    in_data = {64'h0, 32'h55};
    cycle();
    in_data = {64'h0, 32'h66};
    cycle();
    check("d4_full", in_ready, 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("d4_out_valid", out_valid, 32'd0);
    check("d4_out_data", out_data, 32'h0000_0013);
    check("d4_xfer_cnt", xfer_cnt, 32'd3);
    cycle();
    cycle();
    check("d4_no_skid_emit", out_valid, 32'd0);
    check("d4_xfer_still", xfer_cnt, 32'd3);

    // async reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    in_data = {32'h0, 32'h77, 32'h0};
    cycle();
    in_data = {32'h0, 32'h88, 32'h0};
    cycle();
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;
    cycle();
    cycle();
    check("d5_no_emit", out_valid, 32'd0);
    check("d5_xfer_cnt", xfer_cnt, 32'd0);
    check("d5_sel_err_cleared", sel_err, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 4);
      sel = 2'($urandom_range(0, 3));
      in_data = {$urandom(), $urandom(), $urandom()};
      cycle();
    end
    flush = 1'b0;

    // long back-to-back stream, counter wraps
    do_reset();
    out_ready = 1'b1;
    cycle();
    streaming = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      sel = 2'($urandom_range(0, 2));
      in_data = {$urandom(), $urandom(), $urandom()};
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    streaming = 1'b0;
    check("s_xfer_wrap", xfer_cnt, 32'd4464);
    check("s_in_ready_low_cycles", ir_low, 32'd0);
    check("s_drained", out_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mux_reg.md
PIPE_MUX_REG -- requirements
Module: pipe_mux_reg

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter M, default 4, meaning number of selectable inputs (2..16).
REQ-003 The block SHALL have parameter FLUSH_VAL, default 32'h00000013 (NOP), meaning the out_data value after reset or flush, truncated to N bits.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  M*N  flattened inputs; input k occupies bits [k*N+N-1 : k*N].
REQ-007 sel  input  clog2(M)  input select, sampled with in_data.
REQ-008 in_valid  input  1  producer offers in_data/sel.
REQ-009 in_ready  output  1  block can accept.
REQ-010 flush  input  1  synchronous discard of all held entries.
REQ-011 out_data  output  N  head entry data, registered.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  consumer takes out_data.
REQ-014 sel_err  output  1  sticky flag: an accepted sel was >= M.
REQ-015 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-016 accept = in_valid & in_ready; fire = out_valid & out_ready.
REQ-017 The captured word SHALL be in_data slice sel when sel < M, else FLUSH_VAL; an accept with sel >= M SHALL also set sel_err.
REQ-018 Storage SHALL be two entries: head register (drives out_data) and skid register; states EMPTY, ONE, FULL.
REQ-019 EMPTY: accept -> head <= captured word, ONE; out_valid=0.
REQ-020 ONE: accept & fire -> head <= captured word, stay ONE; accept only -> skid <= captured word, FULL; fire only -> EMPTY.
REQ-021 FULL: in_ready=0; fire -> head <= skid, ONE; no fire -> hold.
REQ-022 in_ready SHALL equal (state != FULL) & ~flush, combinational from state and flush only (no path from in_valid or out_ready).
REQ-023 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-024 Latency: a word accepted at edge t SHALL be on out_data with out_valid=1 from edge t onward when the block was EMPTY; ordering is strictly FIFO.
REQ-025 out_data SHALL NOT change while out_valid=1 and out_ready=0.
REQ-026 flush=1 at an edge SHALL force EMPTY, head <= FLUSH_VAL, discard skid, and override any coincident accept or fire; a coincident fire SHALL NOT increment xfer_cnt.
REQ-027 xfer_cnt SHALL increment by 1 on each fire, wrapping 16'hFFFF -> 0.
REQ-028 sel_err SHALL be cleared only by reset and is unaffected by flush.

Reset
REQ-029 rst low SHALL immediately force EMPTY, out_data=FLUSH_VAL, out_valid=0, in_ready=0 while rst is low, sel_err=0, xfer_cnt=0, skid=FLUSH_VAL.
REQ-030 After rst deasserts, in_ready SHALL be 1 from the first clock edge onward; reset asserted mid-transfer SHALL drop all held entries with no fire counted.

Verification
REQ-031 Reset then in_valid=1, sel=2, in_data slice2=32'hA5A5_0002, out_ready=1 -> next edge out_data=32'hA5A5_0002, out_valid=1, xfer_cnt=1 after following edge.
REQ-032 out_ready=0, push 32'h11 then 32'h22 -> state FULL, in_ready=0, out_data=32'h11 held; raise out_ready -> 32'h11 then 32'h22 in order, xfer_cnt=2.
REQ-033 M=3, accept with sel=3 -> out_data=32'h00000013, sel_err=1, remains 1 after flush.
REQ-034 FULL state, flush=1 with out_ready=1 and in_valid=1 same cycle -> next edge out_valid=0, out_data=32'h00000013, xfer_cnt unchanged, skid data never emitted.
REQ-035 Back-to-back stream of 70000 words with out_ready=1 -> one word per cycle, in_ready never 0, xfer_cnt=70000 mod 65536=4464.
REQ-036 Assert rst asynchronously between edges while FULL -> outputs reach reset values before next edge; no data emitted after release until new accept.
